// File: rtl/ow_pkg.sv
// Shared definitions for the 1-wire transaction sequencer: op codes, FSM state
// codes and the default slot timing in clk cycles.
package ow_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RST_LOW   = 3'd1;
  localparam state_t ST_RST_WAIT  = 3'd2;
  localparam state_t ST_SLOT_LOW  = 3'd3;
  localparam state_t ST_SLOT_HIGH = 3'd4;
  localparam state_t ST_RECOV     = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  localparam int DEF_T_RSTL = 480;
  localparam int DEF_T_RSTH = 410;
  localparam int DEF_T_PDS  = 70;
  localparam int DEF_T_SLOT = 70;
  localparam int DEF_T_LOW1 = 6;
  localparam int DEF_T_LOW0 = 60;
  localparam int DEF_T_RDS  = 12;
  localparam int DEF_T_REC  = 10;
  localparam int DEF_CNT_W  = 10;

endpackage

// File: rtl/ow_sync.sv
// Two-flop synchronizer for the raw 1-wire line; resets to the idle (high) level.
module ow_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ow_txn_ctrl.sv
// 1-wire transaction sequencer: turns RESET / WRITE_BYTE / READ_BYTE commands
// into open-drain slot timing and returns a one-cycle response.
module ow_txn_ctrl
  import ow_pkg::*;
#(
  parameter int T_RSTL = DEF_T_RSTL,
  parameter int T_RSTH = DEF_T_RSTH,
  parameter int T_PDS  = DEF_T_PDS,
  parameter int T_SLOT = DEF_T_SLOT,
  parameter int T_LOW1 = DEF_T_LOW1,
  parameter int T_LOW0 = DEF_T_LOW0,
  parameter int T_RDS  = DEF_T_RDS,
  parameter int T_REC  = DEF_T_REC,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_presence,
  output logic       o_rsp_err,
  output logic       o_busy,
  output logic       o_bus_low,
  input  logic       i_bus
);

  localparam logic [CNT_W-1:0] RSTL_END = CNT_W'(T_RSTL - 1);
  localparam logic [CNT_W-1:0] RSTH_END = CNT_W'(T_RSTH - 1);
  localparam logic [CNT_W-1:0] PDS_AT   = CNT_W'(T_PDS);
  localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(T_SLOT - 1);
  localparam logic [CNT_W-1:0] LOW0_END = CNT_W'(T_LOW0 - 1);
  localparam logic [CNT_W-1:0] LOW1_END = CNT_W'(T_LOW1 - 1);
  localparam logic [CNT_W-1:0] RDS_AT   = CNT_W'(T_RDS);
  localparam logic [CNT_W-1:0] REC_END  = CNT_W'(T_REC - 1);

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             presence;
  logic             rd_bit;
  logic             bus_s;
  logic [CNT_W-1:0] low_end;

  ow_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_bus),
    .q     (bus_s)
  );

  assign low_end = (op == OP_WRITE && !shreg[0]) ? LOW0_END : LOW1_END;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op       <= OP_RESET;
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      presence <= 1'b0;
      rd_bit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (i_cmd_valid) begin
            op       <= op_t'(i_cmd_op);
            bit_cnt  <= '0;
            presence <= 1'b0;
            shreg    <= '0;
            case (op_t'(i_cmd_op))
              OP_RESET: state <= ST_RST_LOW;
              OP_WRITE: begin
                shreg <= i_cmd_data;
                state <= ST_SLOT_LOW;
              end
              OP_READ:  state <= ST_SLOT_LOW;
              default: begin
                // Reserved op: one released cycle in RECOV marked as the last
                // bit, so DONE follows on the next cycle.
                state   <= ST_RECOV;
                timer   <= REC_END;
                bit_cnt <= 3'd7;
              end
            endcase
          end
        end

        ST_RST_LOW: begin
          if (timer == RSTL_END) begin
            state <= ST_RST_WAIT;
            timer <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        ST_RST_WAIT: begin
          if (timer == PDS_AT) presence <= !bus_s;
          if (timer == RSTH_END) begin
            state <= ST_DONE;
            timer <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        // Both slot phases share one count measured from slot start, so the
        // high phase is entered with the timer equal to the low length.
        ST_SLOT_LOW: begin
          timer <= timer + CNT_W'(1);
          if (timer == low_end) state <= ST_SLOT_HIGH;
        end

        ST_SLOT_HIGH: begin
          if (op == OP_READ && timer == RDS_AT) rd_bit <= bus_s;
          if (timer == SLOT_END) begin
            state <= ST_RECOV;
            timer <= '0;
            shreg <= {(op == OP_READ) & rd_bit, shreg[7:1]};
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        ST_RECOV: begin
          if (timer == REC_END) begin
            timer <= '0;
            if (bit_cnt == 3'd7) begin
              state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              state   <= ST_SLOT_LOW;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          timer <= '0;
        end

        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign o_cmd_ready    = (state == ST_IDLE) && !reset;
  assign o_busy         = (state != ST_IDLE);
  assign o_bus_low      = (state == ST_RST_LOW) || (state == ST_SLOT_LOW);
  assign o_rsp_valid    = (state == ST_DONE);
  assign o_rsp_data     = (state == ST_DONE && op == OP_READ) ? shreg : 8'h00;
  assign o_rsp_presence = (state == ST_DONE) && (op == OP_RESET) && presence;
  assign o_rsp_err      = (state == ST_DONE) && (op == OP_RSVD);

endmodule
